// File: rtl/fseq_pkg.sv
// Shared types and defaults for the frame clear sequencer.
// Holds the FSM state enum, pixel address type and clear constants.
package fseq_pkg;

    localparam int DEF_WIDTH     = 320;
    localparam int DEF_HEIGHT    = 240;
    localparam int DEF_PIXELS    = DEF_WIDTH * DEF_HEIGHT;
    localparam int DEF_ADDR_BITS = $clog2(DEF_PIXELS);

    typedef logic [DEF_ADDR_BITS-1:0] pixel_addr_t;

    localparam logic [15:0] DEF_CLEAR_COLOR = 16'h0000;
    localparam logic [19:0] DEF_CLEAR_Z     = 20'hFFFFF;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        START_GEN,
        RASTER,
        DONE
    } fseq_state_t;

endpackage

// File: rtl/clear_sweep_counter.sv
// Address sweep for the buffer clear: load-zero, step, saturate at N-1.
// The last flag marks the final address so the FSM can leave CLEAR.
module clear_sweep_counter #(
    parameter int N = 8,
    localparam int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          en,
    output logic [AW-1:0] addr,
    output logic          last
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);

    assign last = (addr == LAST_ADDR);

    // Step the sweep address; hold at N-1 so it never wraps.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            addr <= '0;
        end else if (en && !last) begin
            addr <= addr + AW'(1);
        end
    end

endmodule

// File: rtl/frame_clear_sequencer.sv
// Frame controller: clears fb/zb, starts the rasterizer, forwards writes.
// Optional FSEQ_PERF_EN adds last_frame_cycles frame-length reporting.
module frame_clear_sequencer
    import fseq_pkg::*;
#(
    parameter int DISPLAY_WIDTH  = DEF_WIDTH,
    parameter int DISPLAY_HEIGHT = DEF_HEIGHT,
    parameter int COLOR_BITS     = 16,
    parameter int Z_BITS         = 20,
    parameter logic [COLOR_BITS-1:0] CLEAR_COLOR = COLOR_BITS'(DEF_CLEAR_COLOR),
    parameter logic [Z_BITS-1:0]     CLEAR_Z     = Z_BITS'(DEF_CLEAR_Z),
    localparam int N         = DISPLAY_WIDTH * DISPLAY_HEIGHT,
    localparam int ADDR_BITS = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    output logic                  frame_done,
    output logic                  frame_overrun,
    output logic                  busy,
    output logic                  gen_start,
    input  logic                  gen_done,
    output logic                  gen_wr_ready,
    input  logic                  gen_fb_wr_en,
    input  logic                  gen_zb_wr_en,
    input  logic [ADDR_BITS-1:0]  gen_wr_addr,
    input  logic [COLOR_BITS-1:0] gen_color,
    input  logic [Z_BITS-1:0]     gen_z,
    output logic                  fb_wr_en,
    output logic [ADDR_BITS-1:0]  fb_wr_addr,
    output logic [COLOR_BITS-1:0] fb_wr_data,
    output logic                  zb_wr_en,
    output logic [ADDR_BITS-1:0]  zb_wr_addr,
    output logic [Z_BITS-1:0]     zb_wr_data
`ifdef FSEQ_PERF_EN
    ,
    output logic [31:0]           last_frame_cycles
`endif
);

    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(N - 1);

    fseq_state_t state, state_nx;

    logic [ADDR_BITS-1:0] clr_addr;
    logic clr_last, clr_load, clr_en;

    logic fb_en_nx, zb_en_nx;
    logic [ADDR_BITS-1:0] wr_addr_nx;
    logic [COLOR_BITS-1:0] fb_data_nx;
    logic [Z_BITS-1:0] zb_data_nx;
    logic gen_start_nx, done_nx, overrun_nx;
    logic wr_ok;

    clear_sweep_counter #(.N(N)) u_sweep (
        .clk  (clk),
        .rst  (rst),
        .load (clr_load),
        .en   (clr_en),
        .addr (clr_addr),
        .last (clr_last)
    );

    // gen_wr_ready is the registered RASTER decode, so it gates writes.
    assign wr_ok = gen_wr_ready && (gen_wr_addr <= LAST_ADDR);

    // Next state plus the next value of every registered output.
    always_comb begin
        state_nx     = state;
        clr_load     = 1'b0;
        clr_en       = 1'b0;
        fb_en_nx     = 1'b0;
        zb_en_nx     = 1'b0;
        wr_addr_nx   = '0;
        fb_data_nx   = '0;
        zb_data_nx   = '0;
        gen_start_nx = 1'b0;
        done_nx      = 1'b0;
        overrun_nx   = frame_start && (state != IDLE);
        unique case (state)
            IDLE: begin
                if (frame_start) begin
                    state_nx   = CLEAR;
                    clr_load   = 1'b1;
                    fb_en_nx   = 1'b1;
                    zb_en_nx   = 1'b1;
                    fb_data_nx = CLEAR_COLOR;
                    zb_data_nx = CLEAR_Z;
                end
            end
            CLEAR: begin
                if (clr_last) begin
                    state_nx     = START_GEN;
                    gen_start_nx = 1'b1;
                end else begin
                    clr_en     = 1'b1;
                    fb_en_nx   = 1'b1;
                    zb_en_nx   = 1'b1;
                    wr_addr_nx = clr_addr + ADDR_BITS'(1);
                    fb_data_nx = CLEAR_COLOR;
                    zb_data_nx = CLEAR_Z;
                end
            end
            START_GEN: state_nx = RASTER;
            RASTER: begin
                if (gen_done) begin
                    state_nx = DONE;
                    done_nx  = 1'b1;
                end
                if (wr_ok) begin
                    fb_en_nx   = gen_fb_wr_en;
                    zb_en_nx   = gen_zb_wr_en;
                    wr_addr_nx = gen_wr_addr;
                    fb_data_nx = gen_color;
                    zb_data_nx = gen_z;
                end
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State and output registers; reset drops any in-flight write.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            frame_done    <= 1'b0;
            frame_overrun <= 1'b0;
            busy          <= 1'b0;
            gen_start     <= 1'b0;
            gen_wr_ready  <= 1'b0;
            fb_wr_en      <= 1'b0;
            fb_wr_addr    <= '0;
            fb_wr_data    <= '0;
            zb_wr_en      <= 1'b0;
            zb_wr_addr    <= '0;
            zb_wr_data    <= '0;
        end else begin
            state         <= state_nx;
            frame_done    <= done_nx;
            frame_overrun <= overrun_nx;
            busy          <= (state_nx != IDLE);
            gen_start     <= gen_start_nx;
            gen_wr_ready  <= (state_nx == RASTER);
            fb_wr_en      <= fb_en_nx;
            fb_wr_addr    <= wr_addr_nx;
            fb_wr_data    <= fb_data_nx;
            zb_wr_en      <= zb_en_nx;
            zb_wr_addr    <= wr_addr_nx;
            zb_wr_data    <= zb_data_nx;
        end
    end

`ifdef FSEQ_PERF_EN
    logic [31:0] cyc, cyc_nx;

    // Frame length counter; the request cycle itself counts as one.
    always_comb begin
        cyc_nx = cyc;
        if (state == IDLE && frame_start) begin
            cyc_nx = 32'd1;
        end else if (state != IDLE && cyc != 32'hFFFF_FFFF) begin
            cyc_nx = cyc + 32'd1;
        end
    end

    // Hold the count and capture it as frame_done rises.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc               <= '0;
            last_frame_cycles <= '0;
        end else begin
            cyc <= cyc_nx;
            if (done_nx) begin
                last_frame_cycles <= cyc_nx;
            end
        end
    end
`endif

endmodule

// File: tb/tb_frame_clear_sequencer.sv
// Directed bench for frame_clear_sequencer on a 5x2 display (N=10).
// Perf checks are included when FSEQ_PERF_EN is defined.
module tb_frame_clear_sequencer;

    localparam int W  = 5;
    localparam int H  = 2;
    localparam int N  = W * H;
    localparam int AB = $clog2(N);

    logic clk = 1'b0;
    logic rst;
    logic frame_start;
    logic frame_done, frame_overrun, busy, gen_start, gen_wr_ready;
    logic gen_done, gen_fb_wr_en, gen_zb_wr_en;
    logic [AB-1:0] gen_wr_addr;
    logic [15:0] gen_color;
    logic [19:0] gen_z;
    logic fb_wr_en, zb_wr_en;
    logic [AB-1:0] fb_wr_addr, zb_wr_addr;
    logic [15:0] fb_wr_data;
    logic [19:0] zb_wr_data;
`ifdef FSEQ_PERF_EN
    logic [31:0] last_frame_cycles;
`endif

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;

    frame_clear_sequencer #(
        .DISPLAY_WIDTH  (W),
        .DISPLAY_HEIGHT (H)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .frame_start   (frame_start),
        .frame_done    (frame_done),
        .frame_overrun (frame_overrun),
        .busy          (busy),
        .gen_start     (gen_start),
        .gen_done      (gen_done),
        .gen_wr_ready  (gen_wr_ready),
        .gen_fb_wr_en  (gen_fb_wr_en),
        .gen_zb_wr_en  (gen_zb_wr_en),
        .gen_wr_addr   (gen_wr_addr),
        .gen_color     (gen_color),
        .gen_z         (gen_z),
        .fb_wr_en      (fb_wr_en),
        .fb_wr_addr    (fb_wr_addr),
        .fb_wr_data    (fb_wr_data),
        .zb_wr_en      (zb_wr_en),
        .zb_wr_addr    (zb_wr_addr),
        .zb_wr_data    (zb_wr_data)
`ifdef FSEQ_PERF_EN
        ,
        .last_frame_cycles (last_frame_cycles)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done === 1'b1) done_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic f, input logic z, input logic [AB-1:0] a,
                      input logic [15:0] c, input logic [19:0] d);
        gen_fb_wr_en = f;
        gen_zb_wr_en = z;
        gen_wr_addr  = a;
        gen_color    = c;
        gen_z        = d;
    endtask

    task automatic chk_clear(input int k);
        chk($sformatf("clr_fb_en_%0d", k), 32'(fb_wr_en), 32'd1);
        chk($sformatf("clr_zb_en_%0d", k), 32'(zb_wr_en), 32'd1);
        chk($sformatf("clr_fb_addr_%0d", k), 32'(fb_wr_addr), 32'(k));
        chk($sformatf("clr_zb_addr_%0d", k), 32'(zb_wr_addr), 32'(k));
        chk($sformatf("clr_fb_data_%0d", k), 32'(fb_wr_data), 32'h0000);
        chk($sformatf("clr_zb_data_%0d", k), 32'(zb_wr_data), 32'hFFFFF);
        chk($sformatf("clr_busy_%0d", k), 32'(busy), 32'd1);
        chk($sformatf("clr_gs_%0d", k), 32'(gen_start), 32'd0);
    endtask

    task automatic chk_all_zero(input string t);
        chk({t, "_fb_en"}, 32'(fb_wr_en), 32'd0);
        chk({t, "_zb_en"}, 32'(zb_wr_en), 32'd0);
        chk({t, "_fb_addr"}, 32'(fb_wr_addr), 32'd0);
        chk({t, "_zb_data"}, 32'(zb_wr_data), 32'd0);
        chk({t, "_busy"}, 32'(busy), 32'd0);
        chk({t, "_gs"}, 32'(gen_start), 32'd0);
        chk({t, "_ready"}, 32'(gen_wr_ready), 32'd0);
        chk({t, "_done"}, 32'(frame_done), 32'd0);
        chk({t, "_ovr"}, 32'(frame_overrun), 32'd0);
`ifdef FSEQ_PERF_EN
        chk({t, "_perf"}, last_frame_cycles, 32'd0);
`endif
    endtask

    initial begin
        rst = 1'b1;
        frame_start = 1'b0;
        gen_done = 1'b0;
        wr(1'b0, 1'b0, '0, '0, '0);
        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();
        chk("idle_busy", 32'(busy), 32'd0);

        // Frame 1: full sweep, pass-through, done with a write
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int k = 0; k < N; k++) begin
            chk_clear(k);
            if (k < N - 1) tick();
        end
        tick();
        chk("f1_gs", 32'(gen_start), 32'd1);
        chk("f1_gs_fb_en", 32'(fb_wr_en), 32'd0);
        chk("f1_gs_zb_en", 32'(zb_wr_en), 32'd0);
        chk("f1_gs_ready", 32'(gen_wr_ready), 32'd0);
        tick();
        chk("f1_ready", 32'(gen_wr_ready), 32'd1);
        chk("f1_gs_low", 32'(gen_start), 32'd0);

        wr(1'b1, 1'b1, 4'd5, 16'hF800, 20'h00100);
        tick();
        chk("pt_fb_en", 32'(fb_wr_en), 32'd1);
        chk("pt_fb_addr", 32'(fb_wr_addr), 32'd5);
        chk("pt_fb_data", 32'(fb_wr_data), 32'hF800);
        chk("pt_zb_en", 32'(zb_wr_en), 32'd1);
        chk("pt_zb_addr", 32'(zb_wr_addr), 32'd5);
        chk("pt_zb_data", 32'(zb_wr_data), 32'h00100);

        wr(1'b1, 1'b1, 4'd10, 16'hFFFF, 20'h00001);
        tick();
        chk("oor10_fb_en", 32'(fb_wr_en), 32'd0);
        chk("oor10_zb_en", 32'(zb_wr_en), 32'd0);
        wr(1'b1, 1'b1, 4'd15, 16'hFFFF, 20'h00001);
        tick();
        chk("oor15_fb_en", 32'(fb_wr_en), 32'd0);
        chk("oor15_zb_en", 32'(zb_wr_en), 32'd0);

        wr(1'b0, 1'b1, 4'd7, 16'h1111, 20'h00ABC);
        tick();
        chk("zonly_fb_en", 32'(fb_wr_en), 32'd0);
        chk("zonly_zb_en", 32'(zb_wr_en), 32'd1);
        chk("zonly_zb_addr", 32'(zb_wr_addr), 32'd7);
        chk("zonly_zb_data", 32'(zb_wr_data), 32'h00ABC);

        wr(1'b0, 1'b0, '0, '0, '0);
        tick();
        chk("nowr_fb_en", 32'(fb_wr_en), 32'd0);
        chk("nowr_zb_en", 32'(zb_wr_en), 32'd0);

        gen_done = 1'b1;
        wr(1'b1, 1'b1, 4'd3, 16'h1234, 20'h00333);
        tick();
        gen_done = 1'b0;
        wr(1'b0, 1'b0, '0, '0, '0);
        chk("dn_fb_en", 32'(fb_wr_en), 32'd1);
        chk("dn_fb_addr", 32'(fb_wr_addr), 32'd3);
        chk("dn_fb_data", 32'(fb_wr_data), 32'h1234);
        chk("dn_zb_en", 32'(zb_wr_en), 32'd1);
        chk("dn_zb_data", 32'(zb_wr_data), 32'h00333);
        chk("dn_done", 32'(frame_done), 32'd1);
        chk("dn_ready", 32'(gen_wr_ready), 32'd0);
        chk("dn_busy", 32'(busy), 32'd1);
        tick();
        chk("dn1_done", 32'(frame_done), 32'd0);
        chk("dn1_busy", 32'(busy), 32'd0);
        chk("dn1_fb_en", 32'(fb_wr_en), 32'd0);
`ifdef FSEQ_PERF_EN
        chk("f1_perf", last_frame_cycles, 32'd18);
`endif

        // Writes and gen_done in IDLE are ignored
        wr(1'b1, 1'b1, 4'd2, 16'hAAAA, 20'h00002);
        gen_done = 1'b1;
        tick();
        gen_done = 1'b0;
        wr(1'b0, 1'b0, '0, '0, '0);
        chk("idle_fb_en", 32'(fb_wr_en), 32'd0);
        chk("idle_zb_en", 32'(zb_wr_en), 32'd0);
        chk("idle_done", 32'(frame_done), 32'd0);
        chk("idle_busy2", 32'(busy), 32'd0);

        // Frame 2: overrun during clear and in the DONE cycle
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("f2_addr0", 32'(fb_wr_addr), 32'd0);
        repeat (4) tick();
        chk("f2_addr4", 32'(fb_wr_addr), 32'd4);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("ovr_pulse", 32'(frame_overrun), 32'd1);
        chk("ovr_addr5", 32'(fb_wr_addr), 32'd5);
        chk("ovr_fb_en", 32'(fb_wr_en), 32'd1);
        tick();
        chk("ovr_clr", 32'(frame_overrun), 32'd0);
        chk("ovr_addr6", 32'(fb_wr_addr), 32'd6);
        repeat (3) tick();
        chk("f2_addr9", 32'(fb_wr_addr), 32'd9);
        chk("f2_en9", 32'(zb_wr_en), 32'd1);
        tick();
        chk("f2_gs", 32'(gen_start), 32'd1);
        tick();
        chk("f2_ready", 32'(gen_wr_ready), 32'd1);
        gen_done = 1'b1;
        tick();
        gen_done = 1'b0;
        chk("f2_done", 32'(frame_done), 32'd1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("dovr_pulse", 32'(frame_overrun), 32'd1);
        chk("dovr_busy", 32'(busy), 32'd0);
        chk("dovr_done", 32'(frame_done), 32'd0);
        tick();
        chk("dovr_noq_busy", 32'(busy), 32'd0);
        chk("dovr_noq_fb", 32'(fb_wr_en), 32'd0);
        chk("done_cnt2", 32'(done_cnt), 32'd2);
`ifdef FSEQ_PERF_EN
        chk("f2_perf", last_frame_cycles, 32'd13);
`endif

        // Frame 3: reset mid-clear
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (2) tick();
        chk("f3_addr2", 32'(fb_wr_addr), 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_all_zero("midrst");
        tick();
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_fb", 32'(fb_wr_en), 32'd0);

        // Frame 4: restart at 0, done 5 cycles after ready
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk_clear(0);
        repeat (N - 1) tick();
        chk("f4_addr9", 32'(fb_wr_addr), 32'd9);
        tick();
        chk("f4_gs", 32'(gen_start), 32'd1);
        tick();
        chk("f4_ready", 32'(gen_wr_ready), 32'd1);
        repeat (4) tick();
        gen_done = 1'b1;
        tick();
        gen_done = 1'b0;
        chk("f4_done", 32'(frame_done), 32'd1);
`ifdef FSEQ_PERF_EN
        chk("f4_perf", last_frame_cycles, 32'd17);
`endif
        repeat (3) tick();
        chk("f4_busy", 32'(busy), 32'd0);
        chk("done_cnt3", 32'(done_cnt), 32'd3);
`ifdef FSEQ_PERF_EN
        chk("f4_perf_hold", last_frame_cycles, 32'd17);
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
